// File: rtl/demux_route.sv
// demux_route: registered 1-to-2 demultiplexer.
// A single source value is steered to one of two destinations. Each destination
// owns a 2-entry FIFO with a valid/ready handshake, so backpressure on one
// destination never stalls traffic bound for the other. Each destination also
// has an 8-bit delivery counter that wraps silently.
module demux_route #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    // The buffer is a two-slot shift structure, so DEPTH is only meaningful at 2.
    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    // Per-destination occupancy (0, 1 or 2) plus head and second slot.
    // The head slot drives the output port directly, so a new item is
    // visible the cycle after it is accepted and never bypasses.
    logic [1:0]       occ0;
    logic [1:0]       occ1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] tail0;
    logic [WIDTH-1:0] head1;
    logic [WIDTH-1:0] tail1;

    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    assign full0 = (occ0 == FULL_OCC);
    assign full1 = (occ1 == FULL_OCC);

    // Readiness looks only at fullness: a full buffer refuses a push even when
    // its head is being consumed in the same cycle.
    assign in_ready = in_sel ? !full1 : !full0;

    assign push0 = in_valid && in_ready && !in_sel;
    assign push1 = in_valid && in_ready && in_sel;

    assign out0_valid = (occ0 != 2'd0);
    assign out1_valid = (occ1 != 2'd0);
    assign out0_data  = head0;
    assign out1_data  = head1;

    assign pop0 = out0_valid && out0_ready;
    assign pop1 = out1_valid && out1_ready;

    // Destination 0 buffer: push fills the first free slot, pop shifts the
    // second slot forward; push and pop together only happen at occupancy 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ0  <= 2'd0;
            head0 <= '0;
            tail0 <= '0;
        end else begin
            case ({push0, pop0})
                2'b10: begin
                    if (occ0 == 2'd0) begin
                        head0 <= in_data;
                        occ0  <= 2'd1;
                    end else begin
                        tail0 <= in_data;
                        occ0  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (occ0 == 2'd2) begin
                        head0 <= tail0;
                    end
                    occ0 <= occ0 - 2'd1;
                end
                2'b11: begin
                    head0 <= in_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Destination 1 buffer: same structure as destination 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ1  <= 2'd0;
            head1 <= '0;
            tail1 <= '0;
        end else begin
            case ({push1, pop1})
                2'b10: begin
                    if (occ1 == 2'd0) begin
                        head1 <= in_data;
                        occ1  <= 2'd1;
                    end else begin
                        tail1 <= in_data;
                        occ1  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (occ1 == 2'd2) begin
                        head1 <= tail1;
                    end
                    occ1 <= occ1 - 2'd1;
                end
                2'b11: begin
                    head1 <= in_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Delivery counters: one increment per completed output handshake, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (pop0) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (pop1) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_route.sv
// Testbench for demux_route: table-driven cycles plus hand-written sequences,
// with per-destination scoreboard queues holding expected output order.
module tb_demux_route;

    logic       clk;
    logic       rst_n;
    logic       in_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    demux_route #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       rdy;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model, clock.
    // exp_rdy < 0 means the expected in_ready comes from the scoreboard occupancy.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1, input int exp_rdy,
                         input string tag);
        logic model_rdy;
        logic vld0;
        logic vld1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        model_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
        vld0 = (q0.size() != 0);
        vld1 = (q1.size() != 0);
        if (exp_rdy >= 0)
            check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        else
            check({tag, " in_ready"}, 32'(in_ready), 32'(model_rdy));
        check({tag, " out0_valid"}, 32'(out0_valid), 32'(vld0));
        check({tag, " out1_valid"}, 32'(out1_valid), 32'(vld1));
        if (vld0) check({tag, " out0_data"}, 32'(out0_data), 32'(q0[0]));
        if (vld1) check({tag, " out1_data"}, 32'(out1_data), 32'(q1[0]));
        check({tag, " cnt0"}, 32'(cnt0), 32'(exp_cnt0));
        check({tag, " cnt1"}, 32'(cnt1), 32'(exp_cnt1));
        if (vld0 && r0) begin
            void'(q0.pop_front());
            exp_cnt0 = exp_cnt0 + 8'd1;
        end
        if (vld1 && r1) begin
            void'(q1.pop_front());
            exp_cnt1 = exp_cnt1 + 8'd1;
        end
        if (v && model_rdy) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fields: valid, sel, data, ready0, ready1, expected in_ready
        vecs[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1}; // route to 0
        vecs[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1}; // route to 1, A5 delivered
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1}; // 3C delivered
        vecs[3]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1}; // backpressure fill
        vecs[4]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0}; // buffer 0 full
        vecs[6]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1}; // isolation
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1}; // 77 visible, 0 intact
        vecs[8]  = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1}; // buffer 1 full
        vecs[9]  = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0}; // full + pop: refused
        vecs[10] = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1}; // accepted next cycle
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0}; // release dest 0
        vecs[13] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #12;
        check("reset out0_valid", 32'(out0_valid), 32'd0);
        check("reset out1_valid", 32'(out1_valid), 32'd0);
        check("reset out0_data", 32'(out0_data), 32'd0);
        check("reset out1_data", 32'(out1_data), 32'd0);
        check("reset cnt0", 32'(cnt0), 32'd0);
        check("reset cnt1", 32'(cnt1), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1,
                  int'(vecs[i].rdy), $sformatf("vec%0d", i));
        end
        check("after table cnt0", 32'(cnt0), 32'd4);
        check("after table cnt1", 32'(cnt1), 32'd4);

        // 256 deliveries on destination 0 bring its counter back to where it started.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, -1, "wrap");
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, -1, "wrap drain");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, -1, "wrap idle");
        check("wrap cnt0", 32'(cnt0), 32'd4);
        check("wrap cnt1", 32'(cnt1), 32'd4);

        // Fill both buffers with everything stalled, then reset between edges.
        cycle(1'b1, 1'b0, 8'hE1, 1'b0, 1'b0, -1, "fill");
        cycle(1'b1, 1'b0, 8'hE2, 1'b0, 1'b0, -1, "fill");
        cycle(1'b1, 1'b1, 8'hF1, 1'b0, 1'b0, -1, "fill");
        cycle(1'b1, 1'b1, 8'hF2, 1'b0, 1'b0, 1, "fill");
        check("full in_ready sel1", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out0_valid", 32'(out0_valid), 32'd0);
        check("async rst out1_valid", 32'(out1_valid), 32'd0);
        check("async rst cnt0", 32'(cnt0), 32'd0);
        check("async rst cnt1", 32'(cnt1), 32'd0);
        check("async rst out0_data", 32'(out0_data), 32'd0);
        #1;
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1, "post rst");
        cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1, "post rst");
        cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1, "post rst push");
        check("post rst out1_data", 32'(out1_data), 32'h5A);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, -1, "post rst drain");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, -1, "post rst end");
        check("end cnt1", 32'(cnt1), 32'd1);
        check("end cnt0", 32'(cnt0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
